// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 receiver with glitch-filtered clock, frame checking, a stall
//   watchdog and a show-ahead FIFO of good bytes.
//
//   Parameters
//     FILTER_LEN     ps2c filter depth in clk samples (>=2)
//     DATA_BITS      data bits per frame
//     FIFO_DEPTH     FIFO entries (power of two, >=2)
//     TIMEOUT_CYCLES clk cycles allowed between falling edges inside a frame
//
//   Ports
//     clk             system clock, rising edge
//     reset           synchronous, active-low reset
//     ps2c, ps2d      PS/2 clock and data lines (ps2c asynchronous to clk)
//     rx_en           1 = a new frame may start
//     rd_en           pop the FIFO head (ignored when empty)
//     dout            FIFO head data, valid while rx_valid=1 (0 when empty)
//     rx_valid        FIFO not empty
//     fifo_full       FIFO holds FIFO_DEPTH entries
//     parity_err_tick one-cycle pulse: frame rejected for parity
//     frame_err_tick  one-cycle pulse: frame rejected for start/stop
//     timeout_tick    one-cycle pulse: frame aborted by the watchdog
//     overflow_tick   one-cycle pulse: good frame dropped, FIFO full
//     fsm_state       receiver state for debug (0 IDLE, 1 DPS, 2 CHECK)
//
//   Handshake: rx_valid/dout present the oldest byte; the consumer pops it by
//   holding rd_en high for one cycle while rx_valid=1. rd_en with rx_valid=0
//   has no effect.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int DATA_BITS      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2c,
    input  logic                 ps2d,
    input  logic                 rx_en,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_valid,
    output logic                 fifo_full,
    output logic                 parity_err_tick,
    output logic                 frame_err_tick,
    output logic                 timeout_tick,
    output logic                 overflow_tick,
    output logic [1:0]           fsm_state
);

    localparam int FRAME_W = DATA_BITS + 3;
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam int N_W     = $clog2(DATA_BITS + 2);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [N_W-1:0]   N_LOAD   = N_W'(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DPS   = 2'd1,
        CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // ps2c glitch filter. The shift register also serves as the
    // synchroniser for the asynchronous ps2c: f only moves once every
    // stage agrees, so a metastable first stage cannot produce an edge.
    // ------------------------------------------------------------------
    logic [FILTER_LEN-1:0] filt_reg;
    logic                  f_reg;
    logic                  f_next;
    logic                  fall_edge;

    always_comb begin
        f_next = f_reg;
        if (&filt_reg)
            f_next = 1'b1;
        else if (~|filt_reg)
            f_next = 1'b0;
        fall_edge = f_reg & ~f_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            filt_reg <= '1;
            f_reg    <= 1'b1;
        end else begin
            filt_reg <= {ps2c, filt_reg[FILTER_LEN-1:1]};
            f_reg    <= f_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    state_t             state;
    logic [N_W-1:0]     n_reg;
    logic [FRAME_W-1:0] sh_reg;
    logic [WD_W-1:0]    wd_reg;

    // Frame layout after all shifts: [0]=start, [DATA_BITS:1]=data,
    // [DATA_BITS+1]=parity, [DATA_BITS+2]=stop.
    logic                 frame_bad;
    logic                 parity_bad;
    logic                 frame_good;
    logic [DATA_BITS-1:0] frame_data;

    assign frame_bad  = sh_reg[0] | ~sh_reg[FRAME_W-1];
    // Odd parity: data plus parity must hold an odd number of ones.
    assign parity_bad = ~(^sh_reg[DATA_BITS+1:1]);
    assign frame_good = (state == CHECK) & ~frame_bad & ~parity_bad;
    assign frame_data = sh_reg[DATA_BITS:1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            n_reg           <= '0;
            sh_reg          <= '0;
            wd_reg          <= '0;
            parity_err_tick <= 1'b0;
            frame_err_tick  <= 1'b0;
            timeout_tick    <= 1'b0;
            overflow_tick   <= 1'b0;
        end else begin
            parity_err_tick <= 1'b0;
            frame_err_tick  <= 1'b0;
            timeout_tick    <= 1'b0;
            overflow_tick   <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall_edge && rx_en) begin
                        sh_reg <= {ps2d, sh_reg[FRAME_W-1:1]};
                        n_reg  <= N_LOAD;
                        wd_reg <= '0;
                        state  <= DPS;
                    end
                end
                DPS: begin
                    if (fall_edge) begin
                        sh_reg <= {ps2d, sh_reg[FRAME_W-1:1]};
                        wd_reg <= '0;
                        if (n_reg == '0)
                            state <= CHECK;
                        else
                            n_reg <= n_reg - 1'b1;
                    end else if (wd_reg == WD_LAST) begin
                        // Watchdog clears on every exit, so it never needs
                        // to saturate.
                        timeout_tick <= 1'b1;
                        wd_reg       <= '0;
                        state        <= IDLE;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                CHECK: begin
                    frame_err_tick  <= frame_bad;
                    parity_err_tick <= ~frame_bad & parity_bad;
                    // A pop in the same cycle frees a slot, so full with
                    // rd_en is not an overflow.
                    overflow_tick   <= ~frame_bad & ~parity_bad & fifo_full & ~rd_en;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 push;
    logic                 pop;

    assign pop  = rd_en & rx_valid;
    assign push = frame_good & (~fifo_full | rd_en);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage needs no reset: dout is gated by rx_valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= frame_data;
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rx_valid  <= 1'b0;
            fifo_full <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            rx_valid  <= (count_next != '0);
            fifo_full <= (count_next == CNT_FULL);
        end
    end

    assign dout = rx_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo
//   Directed bench for ps2_rx_fifo. Stimulus tasks push expected bytes into
//   exp_q and expected error ticks into ev_q; a negedge monitor pops and
//   compares whenever the DUT pops a byte or raises a tick.
//   Timing reference: ps2c is driven low 1 time unit after a rising edge;
//   the filtered fall_edge is acted upon at the (FILTER_LEN+1)-th rising
//   edge after that.
module tb_ps2_rx_fifo;

    localparam int FILTER_LEN     = 8;
    localparam int DATA_BITS      = 8;
    localparam int FIFO_DEPTH     = 4;
    localparam int TIMEOUT_CYCLES = 3000;
    localparam int HALF           = 40;
    localparam int HALF_SLOW      = 1000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd2;

    // Tick codes as {timeout, overflow, frame, parity}
    localparam logic [3:0] EV_PAR = 4'b0001;
    localparam logic [3:0] EV_FRM = 4'b0010;
    localparam logic [3:0] EV_OVF = 4'b0100;
    localparam logic [3:0] EV_TO  = 4'b1000;

    logic                 clk;
    logic                 reset;
    logic                 ps2c;
    logic                 ps2d;
    logic                 rx_en;
    logic                 rd_en;
    logic [DATA_BITS-1:0] dout;
    logic                 rx_valid;
    logic                 fifo_full;
    logic                 parity_err_tick;
    logic                 frame_err_tick;
    logic                 timeout_tick;
    logic                 overflow_tick;
    logic [1:0]           fsm_state;

    int total = 0;
    int bad   = 0;

    logic [DATA_BITS-1:0] exp_q[$];
    logic [3:0]           ev_q[$];

    ps2_rx_fifo #(
        .FILTER_LEN    (FILTER_LEN),
        .DATA_BITS     (DATA_BITS),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ps2c           (ps2c),
        .ps2d           (ps2d),
        .rx_en          (rx_en),
        .rd_en          (rd_en),
        .dout           (dout),
        .rx_valid       (rx_valid),
        .fifo_full      (fifo_full),
        .parity_err_tick(parity_err_tick),
        .frame_err_tick (frame_err_tick),
        .timeout_tick   (timeout_tick),
        .overflow_tick  (overflow_tick),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = d;
        f[9]   = ~(^d);
        f[10]  = 1'b1;
        return f;
    endfunction

    // One PS/2 bit: data set while ps2c high, then a low half-period.
    // With glitch=1 a short low pulse is inserted in the high phase.
    task automatic drive_bit(input logic b, input int half, input logic glitch);
        ps2d = b;
        if (glitch) begin
            repeat (15) @(posedge clk);
            #1 ps2c = 1'b0;
            repeat (FILTER_LEN - 1) @(posedge clk);
            #1 ps2c = 1'b1;
            repeat (half - 15 - (FILTER_LEN - 1)) @(posedge clk);
        end else begin
            repeat (half) @(posedge clk);
        end
        #1 ps2c = 1'b0;
        repeat (half) @(posedge clk);
        #1 ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] f, input int half, input logic glitch);
        for (int i = 0; i < 11; i++)
            drive_bit(f[i], half, glitch);
        repeat (4) @(posedge clk);
    endtask

    task automatic read_one();
        @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [3:0] ticks;
        logic [3:0] exp_ev;
        logic [DATA_BITS-1:0] exp_d;
        ticks = {timeout_tick, overflow_tick, frame_err_tick, parity_err_tick};
        if (ticks != 4'b0000) begin
            total++;
            if (ev_q.size() == 0) begin
                bad++;
                $display("FAIL tick_unexpected: got %b expected none", ticks);
            end else begin
                exp_ev = ev_q.pop_front();
                if (ticks !== exp_ev) begin
                    bad++;
                    $display("FAIL tick_kind: got %b expected %b", ticks, exp_ev);
                end
            end
        end
        if (rd_en && rx_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %0h expected nothing", dout);
            end else begin
                exp_d = exp_q.pop_front();
                if (dout !== exp_d) begin
                    bad++;
                    $display("FAIL pop_data: got %0h expected %0h", dout, exp_d);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [10:0] f;
        reset = 1'b0;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rx_en = 1'b1;
        rd_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_valid", rx_valid, 0);
        check("reset_fifo_full", fifo_full, 0);
        check("reset_dout", dout, 0);
        check("reset_ticks", {timeout_tick, overflow_tick, frame_err_tick, parity_err_tick}, 0);
        check("reset_state", fsm_state, ST_IDLE);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        // Good frame 0x1C at ps2c period 2000 clk, with latency check
        f = mk_frame(8'h1C);
        exp_q.push_back(8'h1C);
        for (int i = 0; i < 10; i++)
            drive_bit(f[i], HALF_SLOW, 1'b0);
        ps2d = f[10];
        repeat (HALF_SLOW) @(posedge clk);
        #1 ps2c = 1'b0;
        repeat (FILTER_LEN + 1) @(posedge clk);
        #1 check("lat_stop_edge_rx_valid", rx_valid, 0);
        check("lat_check_state", fsm_state, ST_CHECK);
        @(posedge clk);
        #1 check("lat_rx_valid_rise", rx_valid, 1);
        repeat (HALF_SLOW - FILTER_LEN - 2) @(posedge clk);
        #1 ps2c = 1'b1;
        repeat (10) @(posedge clk);
        read_one();
        #1 check("after_read_empty", rx_valid, 0);
        read_one();
        #1 check("read_when_empty", rx_valid, 0);

        // Parity error
        f = mk_frame(8'h1C);
        f[9] = ~f[9];
        ev_q.push_back(EV_PAR);
        send_frame(f, HALF, 1'b0);
        check("parity_no_data", rx_valid, 0);

        // Stop bit 0
        f = mk_frame(8'h1C);
        f[10] = 1'b0;
        ev_q.push_back(EV_FRM);
        send_frame(f, HALF, 1'b0);
        check("frame_no_data", rx_valid, 0);

        // Fill and overflow
        for (int i = 1; i <= FIFO_DEPTH; i++) begin
            exp_q.push_back(8'(i));
            send_frame(mk_frame(8'(i)), HALF, 1'b0);
            check($sformatf("fill_full_%0d", i), fifo_full, (i == FIFO_DEPTH) ? 1 : 0);
        end
        ev_q.push_back(EV_OVF);
        send_frame(mk_frame(8'h05), HALF, 1'b0);
        check("overflow_still_full", fifo_full, 1);
        for (int i = 0; i < FIFO_DEPTH; i++)
            read_one();
        #1 check("drained_empty", rx_valid, 0);

        // Full plus read in the CHECK cycle of 0x5A
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        send_frame(mk_frame(8'h11), HALF, 1'b0);
        send_frame(mk_frame(8'h22), HALF, 1'b0);
        send_frame(mk_frame(8'h33), HALF, 1'b0);
        send_frame(mk_frame(8'h44), HALF, 1'b0);
        check("pre_5a_full", fifo_full, 1);
        f = mk_frame(8'h5A);
        for (int i = 0; i < 10; i++)
            drive_bit(f[i], HALF, 1'b0);
        ps2d = f[10];
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b0;
        repeat (FILTER_LEN + 1) @(posedge clk);
        #1 check("5a_in_check", fsm_state, ST_CHECK);
        rd_en = 1'b1;
        exp_q.push_back(8'h5A);
        @(posedge clk);
        #1 rd_en = 1'b0;
        check("5a_count_stays_full", fifo_full, 1);
        repeat (HALF - FILTER_LEN - 2) @(posedge clk);
        #1 ps2c = 1'b1;
        repeat (10) @(posedge clk);
        for (int i = 0; i < FIFO_DEPTH; i++)
            read_one();
        #1 check("5a_drained", rx_valid, 0);

        // Timeout: start plus 3 data bits, then ps2c held high
        ev_q.push_back(EV_TO);
        drive_bit(1'b0, HALF, 1'b0);
        drive_bit(1'b1, HALF, 1'b0);
        drive_bit(1'b0, HALF, 1'b0);
        ps2d = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b0;
        repeat (FILTER_LEN + 1) @(posedge clk);
        for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
            @(posedge clk);
            #1;
            if (k == HALF - FILTER_LEN - 1)
                ps2c = 1'b1;
            if (k == TIMEOUT_CYCLES - 1)
                check("timeout_not_early", timeout_tick, 0);
            if (k == TIMEOUT_CYCLES) begin
                check("timeout_on_time", timeout_tick, 1);
                check("timeout_state_idle", fsm_state, ST_IDLE);
            end
        end
        repeat (5) @(posedge clk);
        exp_q.push_back(8'h29);
        send_frame(mk_frame(8'h29), HALF, 1'b0);
        read_one();

        // Glitches: short low pulses in IDLE and inside a frame
        for (int g = 0; g < 3; g++) begin
            @(posedge clk);
            #1 ps2c = 1'b0;
            repeat (FILTER_LEN - 1) @(posedge clk);
            #1 ps2c = 1'b1;
            repeat (12) @(posedge clk);
        end
        #1 check("glitch_idle_state", fsm_state, ST_IDLE);
        exp_q.push_back(8'h3C);
        send_frame(mk_frame(8'h3C), HALF, 1'b1);
        read_one();

        // rx_en=0: whole frame ignored
        rx_en = 1'b0;
        send_frame(mk_frame(8'h55), HALF, 1'b0);
        check("rx_en_off_no_data", rx_valid, 0);
        check("rx_en_off_state", fsm_state, ST_IDLE);
        rx_en = 1'b1;

        // Reset mid-frame, then 0x76
        f = mk_frame(8'hAA);
        for (int i = 0; i < 5; i++)
            drive_bit(f[i], HALF, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check("midreset_state", fsm_state, ST_IDLE);
        check("midreset_rx_valid", rx_valid, 0);
        repeat (5) @(posedge clk);
        exp_q.push_back(8'h76);
        send_frame(mk_frame(8'h76), HALF, 1'b0);
        read_one();
        repeat (5) @(posedge clk);
        #1;
        check("final_rx_valid", rx_valid, 0);
        check("exp_q_drained", exp_q.size(), 0);
        check("ev_q_drained", ev_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised successor to the single-byte PS/2 receiver.
- Filters and edge-detects ps2c, then deserialises the 11-bit PS/2 frame (start, DATA_BITS data LSB-first, odd parity, stop).
- Checks start, stop and parity; aborts stalled frames with a watchdog; queues only good bytes in a show-ahead FIFO.
- Sits between the PS/2 pins and the keyboard scan-code decoder, which drains the FIFO with rd_en.

Parameters:
- FILTER_LEN, 8: ps2c glitch-filter depth in clk samples (>=2).
- DATA_BITS, 8: data bits per frame.
- FIFO_DEPTH, 4: FIFO entries (power of two, >=2).
- TIMEOUT_CYCLES, 50000: clk cycles allowed between consecutive filtered falling edges inside a frame.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- ps2c  in  1  PS/2 clock line, asynchronous to clk.
- ps2d  in  1  PS/2 data line.
- rx_en  in  1  1 = a new frame may start; has no effect on a frame already in progress.
- rd_en  in  1  pop FIFO head; ignored when empty.
- dout  out  DATA_BITS  FIFO head data, valid while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- parity_err_tick  out  1  one-cycle pulse: frame rejected for parity.
- frame_err_tick  out  1  one-cycle pulse: frame rejected for start!=0 or stop!=1.
- timeout_tick  out  1  one-cycle pulse: frame aborted by watchdog.
- overflow_tick  out  1  one-cycle pulse: good frame dropped because FIFO full.

Behaviour:
- Reset (reset=0 at clk edge):
  - Filter shift register is all ones; filtered clock f=1; FSM in IDLE; bit counter, shift register and watchdog are 0.
  - FIFO pointers and count are 0, so rx_valid=0 and fifo_full=0. All ticks are 0. dout is 0.
  - Reset mid-frame discards the partial frame. No tick is raised.
- Filter:
  - Each cycle, ps2c shifts into a FILTER_LEN register.
  - f becomes 1 when all bits are 1, 0 when all bits are 0, and otherwise holds.
  - fall_edge = f_reg & ~f_next (one cycle wide).
- Sampling: ps2d is sampled on fall_edge into a (DATA_BITS+3)-bit right-shift register, new bit at the MSB.
- FSM states:
  - IDLE: on fall_edge & rx_en, shift in the start bit, load n = DATA_BITS+1, clear the watchdog, go to DPS. Edges while rx_en=0 are ignored.
  - DPS: on each fall_edge, shift, clear the watchdog, and decrement n. On the edge that finds n==0 (stop bit), go to CHECK. Without fall_edge the watchdog increments. When the watchdog reaches TIMEOUT_CYCLES-1 and no fall_edge is present, pulse timeout_tick and go to IDLE; the frame is discarded.
  - CHECK: exactly one cycle, then IDLE, evaluated in this priority order:
    - start!=0 or stop!=1: frame_err_tick.
    - Else, XOR of the data and parity bits is 0: parity_err_tick.
    - Else, FIFO full and rd_en=0: overflow_tick, byte dropped.
    - Else, push the data bits.
- Latency: the stop-bit fall_edge is at cycle T. CHECK occurs in T+1. rx_valid=1 and dout=byte from T+2 when the FIFO was empty.
- FIFO:
  - Show-ahead: dout always shows the oldest entry. rd_en with rx_valid=1 pops it at the clk edge.
  - Push and pop in the same cycle keep the count unchanged. This is legal when full: the pop frees a slot, so no overflow.
  - rd_en when empty does nothing. Pointers wrap modulo FIFO_DEPTH.
  - fifo_full and rx_valid are registered from the count.
- Widths: the watchdog is clog2(TIMEOUT_CYCLES) bits, saturation-free because it clears at the limit. n is clog2(DATA_BITS+2) bits.

Test Plan:
- Good frame 0x1C: start 0, data bits 0,0,1,1,1,0,0,0 (LSB first), parity 0, stop 1, with ps2c period 2000 clk. Required: rx_valid rises 2 cycles after the last fall_edge, dout=0x1C, no ticks. Then rd_en for 1 cycle → rx_valid=0.
- Parity error: the same frame with parity 1 → parity_err_tick one cycle, rx_valid stays 0. Stop bit 0 → frame_err_tick only.
- Fill and overflow: send FIFO_DEPTH+1 (5) good frames 0x01..0x05 with no reads. Required: fifo_full=1 after the 4th, overflow_tick on the 5th, then reads return 0x01,0x02,0x03,0x04 in order.
- Full plus simultaneous read: FIFO full; assert rd_en in the CHECK cycle of a good 0x5A frame. Required: no overflow_tick, count stays 4, and the last entry read is 0x5A.
- Timeout: deliver start plus 3 bits, then hold ps2c high. Required: timeout_tick exactly TIMEOUT_CYCLES cycles after the last fall_edge, FSM back in IDLE, and the next full frame 0x29 is received correctly.
- Glitch, rx_en and reset:
  - ps2c low pulses shorter than FILTER_LEN cycles produce no fall_edge.
  - With rx_en=0, a whole frame is ignored.
  - reset=0 mid-frame, then a good frame 0x76 → only 0x76 appears.
